lock_sequencer: RTL and testbench

Main state machine of the digital lock. It accepts keypad digits and compares them against a stored code. It also sequences three external delay timers: the entry-timeout timer, the unlock-hold timer and the lockout timer. Each timer is driven through an enable line and a clear line (tNout), and returns an expired flag (tNin). The block sits between the keypad decoder, the three timer instances and the lock actuator/alarm outputs, all on the frequency-divided clock.

---
 rtl/lock_sequencer.sv | 162 ++++++++++++++++
 tb/tb_lock_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// Digital lock main sequencer: compares keypad digits against a stored code and
// hands out the entry-timeout, unlock-hold and lockout timers.
module lock_sequencer #(
    parameter int unsigned          CODE_LEN  = 4,
    parameter logic [4*CODE_LEN-1:0] CODE     = 16'h1234,
    parameter int unsigned          MAX_FAILS = 3
) (
    input  logic       clkdiv,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       t1in,
    input  logic       t2in,
    input  logic       t3in,
    output logic       t1en,
    output logic       t2en,
    output logic       t3en,
    output logic       t1out,
    output logic       t2out,
    output logic       t3out,
    output logic       unlocked,
    output logic       locked_out,
    output logic       fail_pulse,
    output logic [2:0] fail_count,
    output logic [2:0] digit_count
);

    localparam logic [2:0] LEN_D      = 3'(CODE_LEN);
    localparam logic [2:0] LAST_D     = 3'(CODE_LEN - 1);
    localparam logic [2:0] FAIL_LIMIT = 3'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_UNLOCK  = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       mismatch;
    logic       mismatch_nx;
    logic [2:0] digit_nx;
    logic [2:0] fails_nx;
    logic       restart_nx;
    logic [3:0] expected_digit;
    logic       key_miss;

    // Code digit for the current position; the first digit sits in the top nibble.
    always_comb begin
        expected_digit = 4'(CODE >> {LAST_D - digit_count, 2'b00});
        key_miss       = (key_digit != expected_digit);
    end

    always_ff @(posedge clkdiv or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        mismatch_nx = mismatch;
        digit_nx    = digit_count;
        fails_nx    = fail_count;
        restart_nx  = 1'b0;

        case (state)
            S_IDLE: begin
                if (key_valid) begin
                    digit_nx    = 3'd1;
                    mismatch_nx = key_miss;
                    state_nx    = (LEN_D == 3'd1) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY: begin
                // A key in the same cycle as the timeout wins over the timeout.
                if (key_valid) begin
                    digit_nx    = digit_count + 3'd1;
                    mismatch_nx = mismatch | key_miss;
                    restart_nx  = 1'b1;
                    if (digit_count + 3'd1 == LEN_D) begin
                        state_nx = S_CHECK;
                    end
                end else if (t1in) begin
                    state_nx = S_FAIL;
                end
            end
            S_CHECK: begin
                digit_nx = 3'd0;
                if (mismatch) begin
                    state_nx = S_FAIL;
                end else begin
                    state_nx = S_UNLOCK;
                    fails_nx = 3'd0;
                end
            end
            S_UNLOCK: begin
                if (t2in) begin
                    state_nx = S_IDLE;
                end
            end
            S_FAIL: begin
                state_nx = (fail_count >= FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
            end
            S_LOCKOUT: begin
                if (t3in) begin
                    fails_nx = 3'd0;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx    = S_IDLE;
                digit_nx    = 3'd0;
                mismatch_nx = 1'b0;
            end
        endcase

        // Entering FAIL books the failure so the FAIL cycle already shows the new count.
        if (state_nx == S_FAIL) begin
            fails_nx    = (fail_count == 3'd7) ? 3'd7 : fail_count + 3'd1;
            digit_nx    = 3'd0;
            mismatch_nx = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clkdiv or negedge reset) begin
        if (!reset) begin
            mismatch    <= 1'b0;
            digit_count <= 3'd0;
            fail_count  <= 3'd0;
            unlocked    <= 1'b0;
            locked_out  <= 1'b0;
            fail_pulse  <= 1'b0;
            t1en        <= 1'b0;
            t2en        <= 1'b0;
            t3en        <= 1'b0;
            t1out       <= 1'b1;
            t2out       <= 1'b1;
            t3out       <= 1'b1;
        end else begin
            mismatch    <= mismatch_nx;
            digit_count <= digit_nx;
            fail_count  <= fails_nx;
            unlocked    <= (state_nx == S_UNLOCK);
            locked_out  <= (state_nx == S_LOCKOUT);
            fail_pulse  <= (state_nx == S_FAIL);
            t1en        <= (state_nx == S_ENTRY);
            t2en        <= (state_nx == S_UNLOCK);
            t3en        <= (state_nx == S_LOCKOUT);
            t1out       <= (state_nx != S_ENTRY) || restart_nx;
            t2out       <= (state_nx != S_UNLOCK);
            t3out       <= (state_nx != S_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed vector table, hand-written reset sequence,
// then random traffic against a digit-queue reference model.
module tb_lock_sequencer;

    localparam int CODE_LEN  = 4;
    localparam int MAX_FAILS = 3;
    localparam int MD_IDLE = 0, MD_ENTRY = 1, MD_CHECK = 2, MD_UNLOCK = 3, MD_FAIL = 4, MD_LOCKOUT = 5;

    logic       clkdiv = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       t1in, t2in, t3in;
    logic       t1en, t2en, t3en, t1out, t2out, t3out;
    logic       unlocked, locked_out, fail_pulse;
    logic [2:0] fail_count, digit_count;
    logic [14:0] got;

    lock_sequencer #(.CODE_LEN(CODE_LEN), .CODE(16'h1234), .MAX_FAILS(MAX_FAILS)) dut (
        .clkdiv(clkdiv), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
        .t1in(t1in), .t2in(t2in), .t3in(t3in),
        .t1en(t1en), .t2en(t2en), .t3en(t3en),
        .t1out(t1out), .t2out(t2out), .t3out(t3out),
        .unlocked(unlocked), .locked_out(locked_out), .fail_pulse(fail_pulse),
        .fail_count(fail_count), .digit_count(digit_count)
    );

    always #5 clkdiv = ~clkdiv;

    assign got = {unlocked, locked_out, fail_pulse, t1en, t2en, t3en, t1out, t2out, t3out,
                  fail_count, digit_count};

    int tests = 0;
    int fails = 0;

    // Expected-output constructors, one per observable situation.
    function automatic logic [14:0] ex(logic ul, logic lo, logic fp, logic [2:0] en,
                                       logic [2:0] clr, logic [2:0] fc, logic [2:0] dc);
        return {ul, lo, fp, en, clr, fc, dc};
    endfunction
    function automatic logic [14:0] e_idle(int fc);
        return ex(0, 0, 0, 3'b000, 3'b111, 3'(fc), 3'd0);
    endfunction
    function automatic logic [14:0] e_entry(int fc, int dc, logic r);
        return ex(0, 0, 0, 3'b100, {r, 2'b11}, 3'(fc), 3'(dc));
    endfunction
    function automatic logic [14:0] e_check(int fc);
        return ex(0, 0, 0, 3'b000, 3'b111, 3'(fc), 3'(CODE_LEN));
    endfunction
    function automatic logic [14:0] e_unlock();
        return ex(1, 0, 0, 3'b010, 3'b101, 3'd0, 3'd0);
    endfunction
    function automatic logic [14:0] e_fail(int fc);
        return ex(0, 0, 1, 3'b000, 3'b111, 3'(fc), 3'd0);
    endfunction
    function automatic logic [14:0] e_lock(int fc);
        return ex(0, 1, 0, 3'b001, 3'b110, 3'(fc), 3'd0);
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got {ul,lo,fp,en3,clr3,fc3,dc3}=%b required %b",
                     name, $time, got, exp);
        end
    endtask

    task automatic step(input logic kv, input logic [3:0] dg, input logic a, input logic b,
                        input logic c, input logic [14:0] exp, input string name);
        key_valid = kv; key_digit = dg; t1in = a; t2in = b; t3in = c;
        @(posedge clkdiv);
        #1;
        key_valid = 1'b0; t1in = 1'b0; t2in = 1'b0; t3in = 1'b0;
        check(name, exp);
    endtask

    // Reference model: digits typed so far plus a coarse phase of the lock.
    int code_d[CODE_LEN] = '{1, 2, 3, 4};
    int m_mode;
    int m_fails;
    int q[$];
    bit m_restart;

    task automatic model_reset();
        m_mode = MD_IDLE; m_fails = 0; q.delete(); m_restart = 0;
    endtask

    function automatic bit code_ok();
        if (q.size() != CODE_LEN) return 0;
        for (int i = 0; i < CODE_LEN; i++) if (q[i] != code_d[i]) return 0;
        return 1;
    endfunction

    task automatic model_fail();
        m_mode = MD_FAIL;
        m_fails = (m_fails >= 7) ? 7 : m_fails + 1;
        q.delete();
    endtask

    task automatic model_step(input bit kv, input int dg, input bit a, input bit b, input bit c);
        m_restart = 0;
        case (m_mode)
            MD_IDLE: if (kv) begin
                q.delete(); q.push_back(dg);
                m_mode = (q.size() == CODE_LEN) ? MD_CHECK : MD_ENTRY;
            end
            MD_ENTRY: if (kv) begin
                q.push_back(dg); m_restart = 1;
                if (q.size() == CODE_LEN) m_mode = MD_CHECK;
            end else if (a) model_fail();
            MD_CHECK: if (code_ok()) begin
                m_mode = MD_UNLOCK; m_fails = 0; q.delete();
            end else model_fail();
            MD_UNLOCK: if (b) m_mode = MD_IDLE;
            MD_FAIL: m_mode = (m_fails >= MAX_FAILS) ? MD_LOCKOUT : MD_IDLE;
            default: if (c) begin m_fails = 0; m_mode = MD_IDLE; end
        endcase
    endtask

    function automatic logic [14:0] m_expect();
        case (m_mode)
            MD_IDLE:   return e_idle(m_fails);
            MD_ENTRY:  return e_entry(m_fails, q.size(), m_restart);
            MD_CHECK:  return e_check(m_fails);
            MD_UNLOCK: return e_unlock();
            MD_FAIL:   return e_fail(m_fails);
            default:   return e_lock(m_fails);
        endcase
    endfunction

    task automatic do_reset();
        #2 reset = 1'b0;
        #1 check("async_reset", e_idle(0));
        #2 reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        kv;
        logic [3:0]  dig;
        logic        t1, t2, t3;
        logic [14:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic kv, input logic [3:0] dg, input logic a, input logic b,
                       input logic c, input logic [14:0] exp, input string name);
        vec_t v;
        v.kv = kv; v.dig = dg; v.t1 = a; v.t2 = b; v.t3 = c; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    logic       r_kv, r_a, r_b, r_c;
    logic [3:0] r_dg;
    int         pos;

    initial begin
        reset = 1'b0; key_valid = 1'b0; key_digit = 4'd0; t1in = 1'b0; t2in = 1'b0; t3in = 1'b0;
        repeat (2) @(posedge clkdiv);
        #1 check("reset_state", e_idle(0));
        reset = 1'b1;

        // Correct code with idle gaps, then unlock hold.
        add(1, 1, 0, 0, 0, e_entry(0, 1, 0), "ok_k1");
        add(0, 0, 0, 0, 0, e_entry(0, 1, 0), "ok_gap1");
        add(1, 2, 0, 0, 0, e_entry(0, 2, 1), "ok_k2");
        add(0, 0, 0, 0, 0, e_entry(0, 2, 0), "ok_gap2");
        add(1, 3, 0, 0, 0, e_entry(0, 3, 1), "ok_k3");
        add(0, 0, 0, 0, 0, e_entry(0, 3, 0), "ok_gap3");
        add(1, 4, 0, 0, 0, e_check(0),       "ok_k4_check");
        add(0, 0, 0, 0, 0, e_unlock(),       "ok_unlock");
        add(1, 1, 1, 0, 0, e_unlock(),       "unlock_ignores_key");
        add(0, 0, 0, 1, 0, e_idle(0),        "unlock_t2in");
        // Wrong last digit: full entry, then a single fail pulse.
        add(1, 1, 0, 0, 0, e_entry(0, 1, 0), "bad_k1");
        add(1, 2, 0, 0, 0, e_entry(0, 2, 1), "bad_k2");
        add(1, 3, 0, 0, 0, e_entry(0, 3, 1), "bad_k3");
        add(1, 5, 0, 0, 0, e_check(0),       "bad_k5_check");
        add(0, 0, 0, 0, 0, e_fail(1),        "bad_fail");
        add(0, 0, 0, 0, 0, e_idle(1),        "bad_idle");
        // Timeout after two digits.
        add(1, 1, 0, 0, 0, e_entry(1, 1, 0), "to_k1");
        add(1, 2, 0, 0, 0, e_entry(1, 2, 1), "to_k2");
        add(0, 0, 1, 0, 0, e_fail(2),        "to_fail");
        add(0, 0, 0, 0, 0, e_idle(2),        "to_idle");
        // Key and timeout together: key wins; unlock clears the failure count.
        add(1, 1, 0, 0, 0, e_entry(2, 1, 0), "sim_k1");
        add(1, 2, 0, 0, 0, e_entry(2, 2, 1), "sim_k2");
        add(1, 3, 1, 0, 0, e_entry(2, 3, 1), "sim_k3_t1in");
        add(1, 4, 0, 0, 0, e_check(2),       "sim_k4_check");
        add(0, 0, 0, 0, 0, e_unlock(),       "sim_unlock");
        add(0, 0, 0, 1, 0, e_idle(0),        "sim_idle");
        // Three wrong codes lead to lockout.
        for (int n = 1; n <= MAX_FAILS; n++) begin
            add(1, 9, 0, 0, 0, e_entry(n - 1, 1, 0), "lk_k1");
            add(1, 9, 0, 0, 0, e_entry(n - 1, 2, 1), "lk_k2");
            add(1, 9, 0, 0, 0, e_entry(n - 1, 3, 1), "lk_k3");
            add(1, 9, 0, 0, 0, e_check(n - 1),       "lk_check");
            add(0, 0, 0, 0, 0, e_fail(n),            "lk_fail");
            add(0, 0, 0, 0, 0, (n == MAX_FAILS) ? e_lock(n) : e_idle(n), "lk_after");
        end
        add(1, 1, 0, 0, 0, e_lock(3), "lockout_ignores_key");
        add(0, 0, 1, 1, 0, e_lock(3), "lockout_ignores_t1_t2");
        add(0, 0, 0, 0, 1, e_idle(0), "lockout_t3in");

        foreach (vecs[i])
            step(vecs[i].kv, vecs[i].dig, vecs[i].t1, vecs[i].t2, vecs[i].t3, vecs[i].exp, vecs[i].name);

        // Reset between edges while unlocked, then a fresh first digit.
        step(1, 1, 0, 0, 0, e_entry(0, 1, 0), "rst_k1");
        step(1, 2, 0, 0, 0, e_entry(0, 2, 1), "rst_k2");
        step(1, 3, 0, 0, 0, e_entry(0, 3, 1), "rst_k3");
        step(1, 4, 0, 0, 0, e_check(0),       "rst_k4");
        step(0, 0, 0, 0, 0, e_unlock(),       "rst_unlock");
        do_reset();
        step(1, 1, 0, 0, 0, e_entry(0, 1, 0), "post_reset_k1");
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) begin
                do_reset();
                continue;
            end
            r_kv = ($urandom_range(2) == 0);
            pos  = q.size();
            r_dg = (pos < CODE_LEN && $urandom_range(3) != 0) ? 4'(code_d[pos]) : 4'($urandom_range(15));
            r_a  = ($urandom_range(7) == 0);
            r_b  = ($urandom_range(5) == 0);
            r_c  = ($urandom_range(5) == 0);
            model_step(r_kv, int'(r_dg), r_a, r_b, r_c);
            step(r_kv, r_dg, r_a, r_b, r_c, m_expect(), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
